// File: rtl/distance_filter_if.sv
// Interface between the distance measurement block, the smoothing filter and the BCD stage.
// The master drives raw distance/ready; the slave (the filter) returns filtered distance, start and lock.
interface distance_filter_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] i_distance;
  logic              i_rdy;
  logic [DATA_W-1:0] o_distance;
  logic              o_start;
  logic              o_locked;

  modport master (
    output i_distance,
    output i_rdy,
    input  o_distance,
    input  o_start,
    input  o_locked
  );

  modport slave (
    input  i_distance,
    input  i_rdy,
    output o_distance,
    output o_start,
    output o_locked
  );
endinterface

// File: rtl/distance_filter.sv
// Moving-average smoother for ultrasonic distance readings; zero readings are skipped.
// Optional outlier rejection is compiled in when DIST_FILTER_OUTLIER_EN is defined.
module distance_filter #(
  parameter int DATA_W      = 9,
  parameter int LOG2_DEPTH  = 2,
  parameter int MAX_INVALID = 3,
  parameter int OUTLIER_CM  = 50
) (
  input  logic               i_clk,
  input  logic               i_reset,
  distance_filter_if.slave   bus
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam int CNT_W = $clog2(MAX_INVALID + 1);

  typedef enum logic {
    ST_EMPTY,
    ST_TRACKING
  } state_t;

  state_t                r_state, w_state_next;
  logic [DATA_W-1:0]     r_buf [DEPTH];
  logic [SUM_W-1:0]      r_sum, w_sum_next, w_sum_upd;
  logic [LOG2_DEPTH-1:0] r_ptr, w_ptr_next;
  logic [CNT_W-1:0]      r_inv_cnt, w_inv_cnt_next;
  logic [DATA_W-1:0]     r_distance, w_distance_next;
  logic                  r_start;
  logic                  r_rdy_prev;
  logic                  w_event;
  logic                  w_nonzero;
  logic                  w_outlier;
  logic                  w_seed;
  logic                  w_push;

  assign w_event   = bus.i_rdy & ~r_rdy_prev;
  assign w_nonzero = (bus.i_distance != '0);

  // Sum always contains the entry being replaced, so the subtraction cannot underflow.
  assign w_sum_upd = r_sum - SUM_W'(r_buf[r_ptr]) + SUM_W'(bus.i_distance);

`ifdef DIST_FILTER_OUTLIER_EN
  logic [DATA_W:0] w_abs_diff;
  assign w_abs_diff = (bus.i_distance >= r_distance)
                    ? ({1'b0, bus.i_distance} - {1'b0, r_distance})
                    : ({1'b0, r_distance} - {1'b0, bus.i_distance});
  assign w_outlier  = (w_abs_diff > (DATA_W + 1)'(OUTLIER_CM));
`else
  assign w_outlier  = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_EMPTY;
      r_sum      <= '0;
      r_ptr      <= '0;
      r_inv_cnt  <= '0;
      r_distance <= '0;
      r_start    <= 1'b0;
      // Treat ready as already seen so a level held across reset is not an event.
      r_rdy_prev <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_sum      <= w_sum_next;
      r_ptr      <= w_ptr_next;
      r_inv_cnt  <= w_inv_cnt_next;
      r_distance <= w_distance_next;
      r_start    <= w_event;
      r_rdy_prev <= bus.i_rdy;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_sum_next      = r_sum;
    w_ptr_next      = r_ptr;
    w_inv_cnt_next  = r_inv_cnt;
    w_distance_next = r_distance;
    w_seed          = 1'b0;
    w_push          = 1'b0;

    if (w_event) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_nonzero) begin
            w_seed          = 1'b1;
            w_sum_next      = {bus.i_distance, {LOG2_DEPTH{1'b0}}};
            w_ptr_next      = '0;
            w_inv_cnt_next  = '0;
            w_distance_next = bus.i_distance;
            w_state_next    = ST_TRACKING;
          end else begin
            w_distance_next = '0;
          end
        end
        ST_TRACKING: begin
          if (w_nonzero && !w_outlier) begin
            w_push          = 1'b1;
            w_sum_next      = w_sum_upd;
            w_ptr_next      = r_ptr + 1'b1;
            w_inv_cnt_next  = '0;
            w_distance_next = w_sum_upd[SUM_W-1:LOG2_DEPTH];
          end else if (r_inv_cnt == CNT_W'(MAX_INVALID - 1)) begin
            w_inv_cnt_next  = '0;
            w_distance_next = '0;
            w_state_next    = ST_EMPTY;
          end else begin
            w_inv_cnt_next  = r_inv_cnt + 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Per-entry registers: seeding writes every slot in one cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_buf[gi] <= '0;
        end else if (w_seed || (w_push && (r_ptr == LOG2_DEPTH'(gi)))) begin
          r_buf[gi] <= bus.i_distance;
        end
      end
    end
  endgenerate

  assign bus.o_distance = r_distance;
  assign bus.o_start    = r_start;
  assign bus.o_locked   = (r_state == ST_TRACKING);

endmodule
